// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the tinyCPU datapath.
// Steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK,
// handshakes with memory and drives every per-cycle datapath enable.
module multicycle_control #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [31:0]         instr,
    input  logic                mem_ready,
    input  logic                alu_zero,
    output logic                mem_req,
    output logic                mem_we,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_sel,
    output logic                reg_write,
    output logic [1:0]          wb_sel,
    output logic                alu_src_b,
    output logic [5:0]          ext_op,
    output logic [2:0]          state,
    output logic                halted,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired
);

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEMORY    = 3'd3,
        WRITEBACK = 3'd4,
        HALT      = 3'd5
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [RETIRE_W-1:0] RETIRE_ONE = {{(RETIRE_W-1){1'b0}}, 1'b1};

    state_t cur_state;
    state_t next_state;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jal;
    logic       is_jalr;
    logic       is_system;
    logic       is_known;
    logic       branch_taken;
    logic       retire;
    logic       set_halt;
    logic       set_illegal;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign rd     = instr[11:7];

    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_jal    = (opcode == OPC_JAL);
    assign is_jalr   = (opcode == OPC_JALR);
    assign is_system = (opcode == OPC_SYSTEM);

    assign state = cur_state;

    // Classify the opcode: known set, branch outcome and immediate format.
    always_comb begin
        is_known     = 1'b0;
        ext_op       = 6'b000000;
        branch_taken = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_OPIMM, OPC_JALR: begin is_known = 1'b1; ext_op = 6'b000010; end
            OPC_STORE:                     begin is_known = 1'b1; ext_op = 6'b000001; end
            OPC_BRANCH:                    begin is_known = 1'b1; ext_op = 6'b000100; end
            OPC_LUI, OPC_AUIPC:            begin is_known = 1'b1; ext_op = 6'b000101; end
            OPC_JAL:                       begin is_known = 1'b1; ext_op = 6'b000110; end
            OPC_OP, OPC_SYSTEM:            is_known = 1'b1;
            default:                       is_known = 1'b0;
        endcase
        // The immediate generator is idle while the IR is still being loaded.
        if (cur_state == FETCH) begin
            ext_op = 6'b000000;
        end
        if (funct3 == 3'b000) begin
            branch_taken = alu_zero;
        end else if (funct3 == 3'b001) begin
            branch_taken = !alu_zero;
        end
    end

    // Next-state logic and per-state datapath enables.
    always_comb begin
        next_state  = cur_state;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_sel      = 2'b00;
        reg_write   = 1'b0;
        wb_sel      = 2'b00;
        alu_src_b   = !((opcode == OPC_OP) || is_branch);
        retire      = 1'b0;
        set_halt    = 1'b0;
        set_illegal = 1'b0;
        case (cur_state)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    next_state = DECODE;
                end
            end
            DECODE: begin
                if (is_system) begin
                    set_halt   = 1'b1;
                    next_state = HALT;
                end else if (!is_known) begin
                    set_illegal = 1'b1;
                    next_state  = HALT;
                end else begin
                    next_state = EXECUTE;
                end
            end
            EXECUTE: begin
                if (is_branch) begin
                    pc_write   = 1'b1;
                    pc_sel     = branch_taken ? 2'b01 : 2'b00;
                    retire     = 1'b1;
                    next_state = FETCH;
                end else if (is_load || is_store) begin
                    next_state = MEMORY;
                end else begin
                    next_state = WRITEBACK;
                end
            end
            MEMORY: begin
                mem_req = 1'b1;
                mem_we  = is_store;
                if (mem_ready) begin
                    if (is_store) begin
                        pc_write   = 1'b1;
                        retire     = 1'b1;
                        next_state = FETCH;
                    end else begin
                        next_state = WRITEBACK;
                    end
                end
            end
            WRITEBACK: begin
                reg_write  = (rd != 5'd0);
                wb_sel     = is_load ? 2'b01 : ((is_jal || is_jalr) ? 2'b10 : 2'b00);
                pc_write   = 1'b1;
                pc_sel     = is_jal ? 2'b01 : (is_jalr ? 2'b10 : 2'b00);
                retire     = 1'b1;
                next_state = FETCH;
            end
            HALT: begin
                next_state = HALT;
            end
            default: begin
                next_state = FETCH;
            end
        endcase
        // While reset is held no side effect may escape, even mid-handshake.
        if (!rstn) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
        end
    end

    // State register plus sticky status flags and the retired counter.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cur_state <= FETCH;
            halted    <= 1'b0;
            illegal   <= 1'b0;
            retired   <= '0;
        end else begin
            cur_state <= next_state;
            if (set_halt) begin
                halted <= 1'b1;
            end
            if (set_illegal) begin
                illegal <= 1'b1;
            end
            if (retire) begin
                retired <= retired + RETIRE_ONE;
            end
        end
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the tinyCPU datapath. It steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK, and handshakes with instruction/data memory. It drives the immediate generator's EXTOp code plus the PC, IR, register-file and memory enables. It sits between the instruction register and the datapath muxes and owns all per-cycle control.

## Interface
Parameters:
- RETIRE_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rstn  in  1  reset, synchronous and active-low.
- instr  in  32  current instruction word from the IR; stable from DECODE onward.
- mem_ready  in  1  memory completion strobe for the current request.
- alu_zero  in  1  ALU zero flag, valid during EXECUTE.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  write qualifier for mem_req (stores only).
- ir_write  out  1  load IR with the fetched word.
- pc_write  out  1  update PC.
- pc_sel  out  2  PC source: 00 = pc+4, 01 = pc+imm (branch/JAL), 10 = rs1+imm (JALR).
- reg_write  out  1  register-file write enable.
- wb_sel  out  2  writeback source: 00 = ALU, 01 = memory data, 10 = pc+4.
- alu_src_b  out  1  ALU operand B: 0 = rs2, 1 = immediate.
- ext_op  out  6  immediate-format code to the immediate generator.
- state  out  3  current state, for debug.
- halted  out  1  sticky; set on SYSTEM opcode.
- illegal  out  1  sticky; set on an undecodable opcode.
- retired  out  RETIRE_W  count of completed instructions.

## Operation
- State encoding: FETCH = 0, DECODE = 1, EXECUTE = 2, MEMORY = 3, WRITEBACK = 4, HALT = 5.
- State, halted, illegal and retired are registered. All other outputs are combinational from the state and instr[6:0] / instr[14:12] / instr[11:7].
- ext_op by opcode:
  - 0000011, 0010011, 1100111 → 000010 (I).
  - 0100011 → 000001 (S).
  - 1100011 → 000100 (B).
  - 0110111, 0010111 → 000101 (U).
  - 1101111 → 000110 (J).
  - All else, and always in FETCH → 000000.
- alu_src_b = 1 for every opcode except 0110011 and 1100011.
- FETCH:
  - Assert mem_req with mem_we = 0.
  - On mem_ready, pulse ir_write and go to DECODE. Otherwise stay.
- DECODE:
  - Opcode 1110011 → HALT, set halted.
  - Opcode not in the ten listed above → HALT, set illegal.
  - Otherwise → EXECUTE.
- EXECUTE:
  - Branch:
    - Taken when (funct3 = 000 and alu_zero) or (funct3 = 001 and !alu_zero).
    - Assert pc_write with pc_sel = 01 if taken, 00 if not; increment retired.
    - Any other funct3 is treated as not taken. Next state FETCH.
  - Load or store → MEMORY.
  - All others → WRITEBACK.
- MEMORY:
  - Assert mem_req; mem_we = 1 for stores.
  - Stay until mem_ready.
  - On mem_ready, a store asserts pc_write (pc_sel = 00), increments retired and goes to FETCH; a load goes to WRITEBACK.
- WRITEBACK (one cycle):
  - reg_write = 1 unless rd = 0.
  - wb_sel: 01 for loads, 10 for JAL/JALR, 00 otherwise.
  - pc_write = 1 with pc_sel 01 for JAL, 10 for JALR, 00 otherwise.
  - Increment retired; next state FETCH.
- HALT:
  - Absorbing state; all enables are 0. Leave only via reset.
- retired wraps modulo 2^RETIRE_W.
- Outside the cases listed above, every enable is 0 and wb_sel / pc_sel are 00.

## Timing
- Reset (rstn low at a rising edge) takes effect in any state, including mid-handshake. After it:
  - state = FETCH, halted = 0, illegal = 0, retired = 0.
  - The combinational outputs follow FETCH: mem_req = 1 once rstn is high, ext_op = 0, all other enables 0.
- mem_ready is sampled only in FETCH and MEMORY; it is ignored in all other states.
- mem_ready in the same cycle mem_req first rises completes the access; zero wait states are allowed.
- Minimum latency with zero wait states:
  - Branch: 3 cycles.
  - Store: 4 cycles.
  - ALU/U/JAL/JALR: 4 cycles.
  - Load: 5 cycles.
- Each wait state adds one cycle.
- pc_write, reg_write and ir_write are single-cycle pulses per instruction.
- retired increments on the same edge that the final pc_write commits.

## Test plan
- ADDI x1,x0,5 (0x00500093), mem_ready always 1 → state sequence 0,1,2,4,0; ext_op = 000010 in states 1–4; reg_write one cycle in WRITEBACK; retired = 1.
- LW with mem_ready delayed 3 cycles in MEMORY → MEMORY held 4 cycles with mem_req = 1, mem_we = 0; WRITEBACK wb_sel = 01; total 8 cycles.
- BEQ (0x00208463) with alu_zero = 1, then BNE with alu_zero = 1 → first: pc_sel = 01, pc_write in EXECUTE, 3 cycles. Second: pc_sel = 00.
- JAL x1 (0x008000EF) → ext_op = 000110; WRITEBACK wb_sel = 10, pc_sel = 01, reg_write = 1. Same encoding with rd = 0 → reg_write = 0.
- Opcode 0x0000007F → HALT, illegal = 1, all enables 0 for 10+ cycles. Then ECALL (0x00000073) after reset → HALT, halted = 1, illegal = 0.
- rstn low during MEMORY of a store waiting on mem_ready → next edge state = FETCH, retired = 0, mem_we = 0; no pc_write is issued.
